// File: rtl/tmu_readback.sv
// TMU readback: decimated capture of PID/CORDIC outputs into a show-ahead FIFO drained over valid/ready.
// Optional per-entry cycle timestamp (rd_ts) is enabled by defining TMU_READBACK_TS_EN.
module tmu_readback #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [16:0]   pid_in,
    input  logic [11:0]   cordic_in,
    input  logic          capture_en,
    input  logic [7:0]    decim,
    input  logic          clr_ovf,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [31:0]   rd_data,
    output logic [AW:0]   level,
    output logic          ovf
`ifdef TMU_READBACK_TS_EN
    ,
    output logic [15:0]   rd_ts
`endif
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    seq_q, seq_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   wr_word_s;
    logic          strobe_s, pop_s, push_s;

    // Strobe, push/pop arbitration and next-state for counters, pointers and flags
    always_comb begin
        strobe_s  = capture_en && (cnt_q >= decim);
        pop_s     = (level_q != '0) && rd_ready;
        // A full FIFO still accepts a sample when the head leaves in the same cycle
        push_s    = strobe_s && ((level_q < DEPTH_L) || pop_s);
        wr_word_s = {seq_q, pid_in, cordic_in};

        if (!capture_en) begin
            cnt_d = 8'd0;
        end else if (strobe_s) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        if (strobe_s) begin
            seq_d = seq_q + 3'd1;
        end else begin
            seq_d = seq_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase

        if (strobe_s && !push_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= 8'd0;
            seq_q    <= 3'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_word_s;
            end
        end
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign level    = level_q;
    assign ovf      = ovf_q;

`ifdef TMU_READBACK_TS_EN
    logic [15:0] ts_q, ts_d;
    logic [15:0] ts_mem_q [DEPTH];

    // Free-running timestamp and per-entry timestamp storage
    always_comb begin
        ts_d = ts_q + 16'd1;
    end

    // Timestamp registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem_q[i] <= 16'd0;
            end
        end else begin
            ts_q <= ts_d;
            if (push_s) begin
                ts_mem_q[wr_ptr_q] <= ts_q;
            end
        end
    end

    assign rd_ts = rd_valid ? ts_mem_q[rd_ptr_q] : 16'd0;
`endif

endmodule

// File: tb/tb_tmu_readback.sv
// Self-checking bench for tmu_readback: random traffic against a queue-based reference model,
// followed by directed decimation, overflow, full-with-pop, clear-vs-drop and mid-stream reset steps.
module tb_tmu_readback;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [16:0] pid_in = 17'd0;
    logic [11:0] cordic_in = 12'd0;
    logic        capture_en = 1'b0;
    logic [7:0]  decim = 8'd0;
    logic        clr_ovf = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  level;
    logic        ovf;
`ifdef TMU_READBACK_TS_EN
    logic [15:0] rd_ts;
    logic [15:0] qts[$];
    int          mts;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q[$];
    logic [2:0]  mseq;
    int          mcnt;
    bit          movf;

    tmu_readback #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk(clk), .rstn(rstn), .pid_in(pid_in), .cordic_in(cordic_in),
        .capture_en(capture_en), .decim(decim), .clr_ovf(clr_ovf),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .ovf(ovf)
`ifdef TMU_READBACK_TS_EN
        , .rd_ts(rd_ts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, (q.size() != 0)});
        chk("rd_data", rd_data, (q.size() != 0) ? q[0] : 32'd0);
        chk("level", 32'(level), 32'(q.size()));
        chk("ovf", {31'd0, ovf}, {31'd0, movf});
`ifdef TMU_READBACK_TS_EN
        chk("rd_ts", {16'd0, rd_ts}, {16'd0, (qts.size() != 0) ? qts[0] : 16'd0});
`endif
    endtask

    // One clock cycle with the current inputs; the model applies the rules at the edge.
    task automatic tick();
        bit strobe, pop, drop;
        pop    = (q.size() != 0) && rd_ready;
        strobe = capture_en && (mcnt >= int'(decim));
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
`ifdef TMU_READBACK_TS_EN
            void'(qts.pop_front());
`endif
        end
        drop = 1'b0;
        if (strobe) begin
            if (q.size() < DEPTH) begin
                q.push_back({mseq, pid_in, cordic_in});
`ifdef TMU_READBACK_TS_EN
                qts.push_back(16'(mts));
`endif
            end else begin
                drop = 1'b1;
            end
            mseq = mseq + 3'd1;
        end
        if (drop) movf = 1'b1;
        else if (clr_ovf) movf = 1'b0;
        mcnt = !capture_en ? 0 : (strobe ? 0 : mcnt + 1);
`ifdef TMU_READBACK_TS_EN
        mts = (mts + 1) % 65536;
`endif
        @(negedge clk);
        check_model();
    endtask

    // Asynchronous reset asserted between clock edges, checked before the next edge.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        q.delete();
        mseq = 3'd0;
        mcnt = 0;
        movf = 1'b0;
`ifdef TMU_READBACK_TS_EN
        qts.delete();
        mts = 0;
`endif
        #1;
        check_model();
        @(negedge clk);
        capture_en = 1'b0;
        clr_ovf    = 1'b0;
        rd_ready   = 1'b0;
        rstn       = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        int          pulses;

        // Reset state and random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            capture_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) decim = 8'($urandom_range(0, 4));
            rd_ready   = ($urandom_range(0, 2) != 0);
            clr_ovf    = ($urandom_range(0, 7) == 0);
            pid_in     = 17'($urandom);
            cordic_in  = 12'($urandom);
            tick();
        end

        // decim=3 with a constant sample: one valid pulse every four cycles
        do_reset();
        clr_ovf = 1'b0; decim = 8'd3; capture_en = 1'b1; rd_ready = 1'b1;
        pid_in = 17'h1ABCD; cordic_in = 12'h5A5;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rd_valid) begin
                pulses++;
                w = rd_data;
                chk("decim3_payload", {3'd0, w[28:0]}, {3'd0, 17'h1ABCD, 12'h5A5});
            end
        end
        chk("decim3_pulses", 32'(pulses), 32'd3);

        // Saturation with rd_ready low, then drain and observe the seq gap
        do_reset();
        decim = 8'd0; capture_en = 1'b1; rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_level", 32'(level), 32'd8);
        chk("sat_ovf", {31'd0, ovf}, 32'd1);
        w = rd_data;
        chk("sat_head_seq", {29'd0, w[31:29]}, 32'd0);
        capture_en = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = rd_data;
            chk("drain_seq", {29'd0, w[31:29]}, 32'(i));
            tick();
        end
        capture_en = 1'b1;
        tick();
        w = rd_data;
        chk("gap_seq", {29'd0, w[31:29]}, 32'd2);

        // Full FIFO, pop and strobe in the same cycle: slot reused, no overflow
        do_reset();
        decim = 8'd0; capture_en = 1'b1; rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rd_ready = 1'b1;
        tick();
        chk("reuse_level", 32'(level), 32'd8);
        chk("reuse_ovf", {31'd0, ovf}, 32'd0);

        // Clear coinciding with a drop: set wins; clear alone then clears
        rd_ready = 1'b0; clr_ovf = 1'b1;
        tick();
        chk("clr_vs_drop", {31'd0, ovf}, 32'd1);
        capture_en = 1'b0;
        tick();
        chk("clr_alone", {31'd0, ovf}, 32'd0);
        clr_ovf = 1'b0;

        // Reset with five entries buffered; first word afterwards has seq 0
        do_reset();
        decim = 8'd0; capture_en = 1'b1; rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_level", 32'(level), 32'd5);
        do_reset();
        chk("post_reset_level", 32'(level), 32'd0);
        capture_en = 1'b1; decim = 8'd0;
        tick();
        w = rd_data;
        chk("post_reset_seq", {29'd0, w[31:29]}, 32'd0);

`ifdef TMU_READBACK_TS_EN
        // Timestamps spaced by decim+1 cycles
        do_reset();
        decim = 8'd9; capture_en = 1'b1; rd_ready = 1'b1;
        begin
            int last_ts;
            last_ts = -1;
            for (int i = 0; i < 45; i++) begin
                tick();
                if (rd_valid) begin
                    if (last_ts >= 0) chk("ts_delta", 32'(int'(rd_ts) - last_ts), 32'd10);
                    last_ts = int'(rd_ts);
                end
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
